// File: rtl/ifetch_pc_ctrl.sv
// IFETCH program-counter / fetch-control stage: PC register, imem req/ack fetch, IF/ID capture, redirects.
// Optional misaligned-target trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [3:0]  pcplus4_hi,
  output logic        misalign_exc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_tgt;
  logic        pend_vld;
  logic        redir;
  logic        ack;
  logic        consume;
  logic [31:0] tgt_raw;
  logic [31:0] redir_pc;

  assign redir   = (jump | branch) & ~stall;
  assign tgt_raw = jump ? jump_target : branch_target;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic mis;
  assign mis      = redir & (tgt_raw[1:0] != 2'b00);
  assign redir_pc = mis ? EXC_VECTOR : (tgt_raw & ~32'd3);

  always_ff @(posedge clk) begin
    if (rst) misalign_exc <= 1'b0;
    else     misalign_exc <= mis;
  end
`else
  assign redir_pc     = tgt_raw & ~32'd3;
  // trap disabled: vector has no effect
  assign misalign_exc = 1'b0 & |EXC_VECTOR;
`endif

  // Request drops the same cycle IF/ID is full and stalled, so no ack can overwrite it.
  assign imem_req   = (state == REQ) & ~(instr_valid & stall);
  assign imem_addr  = pc;
  assign ack        = imem_req & imem_ack;
  assign consume    = instr_valid & ~stall;
  assign pcplus4_hi = pc_out[31:28] + {3'b000, &pc_out[27:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_tgt    <= 32'h0;
      pend_vld    <= 1'b0;
      instr_out   <= 32'h0;
      instr_valid <= 1'b0;
      pc_out      <= 32'h0;
    end else begin
      if (consume) instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          state <= REQ;
          if (redir) pc <= redir_pc;
        end
        HOLD: begin
          if (!stall) begin
            state <= REQ;
            if (redir) pc <= redir_pc;
          end
        end
        REQ: begin
          if (redir) begin
            instr_valid <= 1'b0;
            if (ack) begin
              pc       <= redir_pc;
              pend_vld <= 1'b0;
            end else begin
              // fetch in flight: keep imem_addr stable, apply target when its ack lands
              pend_vld <= 1'b1;
              pend_tgt <= redir_pc;
            end
          end else if (ack) begin
            if (pend_vld) begin
              pc       <= pend_tgt;
              pend_vld <= 1'b0;
            end else begin
              instr_out   <= imem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
              if (stall) state <= HOLD;
            end
          end else if (instr_valid & stall) begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_pc_ctrl.sv
// Directed bench for ifetch_pc_ctrl: vector table for sequential fetch/stall/redirect, then hand sequences.
module tb_ifetch_pc_ctrl;
  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst, stall, jump, branch;
  logic [31:0] jump_target, branch_target;
  logic        imem_req, imem_ack, instr_valid, misalign_exc;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;
  logic [3:0]  pcplus4_hi;
  logic        auto_ack, force_ack;
  int          total = 0;
  int          bad = 0;

  ifetch_pc_ctrl #(.RESET_PC(32'h0), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_target(branch_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out),
    .pcplus4_hi(pcplus4_hi), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  // memory model: returns addr^K, acks same cycle when auto, or on demand
  always_comb begin
    imem_ack   = force_ack | (auto_ack & imem_req);
    imem_rdata = imem_addr ^ K;
  end

  typedef struct {
    logic        s, j, b;
    logic [31:0] jt, bt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic j, input logic b,
                      input logic [31:0] jt, input logic [31:0] bt, input logic fa);
    stall = s; jump = j; branch = b; jump_target = jt; branch_target = bt; force_ack = fa;
    @(posedge clk); #1;
  endtask

  task automatic chk_if(input string tag, input logic req, input logic [31:0] addr,
                        input logic vld, input logic [31:0] pc);
    chk({tag, ".req"},   {31'h0, imem_req}, {31'h0, req});
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, vld});
    chk({tag, ".pc"},    pc_out, pc);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0,0,0,0,0,                  1, 32'h0,         0, 32'h0,         32'h0};
    tbl[1]  = '{0,0,0,0,0,                  1, 32'h4,         1, 32'h0,         32'h0 ^ K};
    tbl[2]  = '{0,0,0,0,0,                  1, 32'h8,         1, 32'h4,         32'h4 ^ K};
    tbl[3]  = '{0,0,0,0,0,                  1, 32'hC,         1, 32'h8,         32'h8 ^ K};
    tbl[4]  = '{1,0,0,0,0,                  0, 32'hC,         1, 32'h8,         32'h8 ^ K};
    tbl[5]  = '{1,0,0,0,0,                  0, 32'hC,         1, 32'h8,         32'h8 ^ K};
    tbl[6]  = '{1,0,0,0,0,                  0, 32'hC,         1, 32'h8,         32'h8 ^ K};
    tbl[7]  = '{0,0,0,0,0,                  1, 32'hC,         0, 32'h8,         32'h8 ^ K};
    tbl[8]  = '{0,0,0,0,0,                  1, 32'h10,        1, 32'hC,         32'hC ^ K};
    tbl[9]  = '{0,1,1,32'h0040_0100,32'h300,1, 32'h0040_0100, 0, 32'hC,         32'hC ^ K};
    tbl[10] = '{0,0,0,0,0,                  1, 32'h0040_0104, 1, 32'h0040_0100, 32'h0040_0100 ^ K};

    rst = 1'b1; auto_ack = 1'b1; force_ack = 1'b0;
    stall = 0; jump = 0; branch = 0; jump_target = 0; branch_target = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_if("reset", 0, 32'h0, 0, 32'h0);
    chk("reset.instr", instr_out, 32'h0);
    chk("reset.hi", {28'h0, pcplus4_hi}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].s, tbl[i].j, tbl[i].b, tbl[i].jt, tbl[i].bt, 0);
      chk_if($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc);
      chk($sformatf("vec%0d.instr", i), instr_out, tbl[i].e_ins);
    end

    // branch while a fetch is outstanding: late ack data discarded
    auto_ack = 1'b0;
    step(0, 1, 0, 32'h10, 0, 0);
    chk_if("pend_jump", 1, 32'h0040_0104, 0, 32'h0040_0100);
    step(0, 0, 0, 0, 0, 1);
    chk_if("pend_ack", 1, 32'h10, 0, 32'h0040_0100);
    step(0, 0, 1, 0, 32'h200, 0);
    chk_if("pend_br", 1, 32'h10, 0, 32'h0040_0100);
    step(0, 0, 0, 0, 0, 0);
    chk_if("pend_wait", 1, 32'h10, 0, 32'h0040_0100);
    step(0, 0, 0, 0, 0, 1);
    chk_if("pend_late_ack", 1, 32'h200, 0, 32'h0040_0100);
    auto_ack = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk_if("br_fetch", 1, 32'h204, 1, 32'h200);
    chk("br_fetch.instr", instr_out, 32'h200 ^ K);

    // PC wrap at top of address space
    step(0, 1, 0, 32'hFFFF_FFFC, 0, 0);
    chk_if("wrap_jump", 1, 32'hFFFF_FFFC, 0, 32'h200);
    step(0, 0, 0, 0, 0, 0);
    chk_if("wrap_top", 1, 32'h0, 1, 32'hFFFF_FFFC);
    chk("wrap_top.hi", {28'h0, pcplus4_hi}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk_if("wrap_zero", 1, 32'h4, 1, 32'h0);
    step(0, 1, 0, 32'h1000_0000, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_if("hi_one", 1, 32'h1000_0004, 1, 32'h1000_0000);
    chk("hi_one.hi", {28'h0, pcplus4_hi}, 32'h1);

    // misaligned branch target
    step(0, 0, 1, 0, 32'h0000_0102, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk_if("mis_br", 1, EXC, 0, 32'h1000_0000);
    chk("mis_br.exc", {31'h0, misalign_exc}, 32'h1);
    step(1, 0, 0, 0, 0, 0);
    chk("mis_pulse", {31'h0, misalign_exc}, 32'h0);
    chk_if("stall_empty", 0, EXC + 32'd4, 1, EXC);
`else
    chk_if("mis_br", 1, 32'h100, 0, 32'h1000_0000);
    chk("mis_br.exc", {31'h0, misalign_exc}, 32'h0);
    // stall with empty IF/ID still fetches, then holds
    step(1, 0, 0, 0, 0, 0);
    chk_if("stall_empty", 0, 32'h104, 1, 32'h100);
`endif
    step(0, 0, 0, 0, 0, 0);
    chk("stall_release.req", {31'h0, imem_req}, 32'h1);

    // reset mid-REQ with an ack during reset
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_if("rst_mid", 0, 32'h0, 0, 32'h0);
    chk("rst_mid.instr", instr_out, 32'h0);
    chk("rst_mid.hi", {28'h0, pcplus4_hi}, 32'h0);
    chk("rst_mid.exc", {31'h0, misalign_exc}, 32'h0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk_if("rst_release", 1, 32'h0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
